// File: rtl/prbs_frame_ctrl_if.sv
// Bit-serial valid/ready stream from the PRBS frame controller to its consumer.
// The master drives the bit, its valid flag and the end-of-frame marker; the
// slave answers with ready.
interface prbs_frame_ctrl_if;
    logic bit_out;
    logic bit_valid;
    logic bit_ready;
    logic frame_last;

    modport master (
        output bit_out,
        output bit_valid,
        output frame_last,
        input  bit_ready
    );

    modport slave (
        input  bit_out,
        input  bit_valid,
        input  frame_last,
        output bit_ready
    );
endinterface

// File: rtl/prbs_frame_ctrl.sv
// prbs_frame_ctrl: frame controller around an 8-bit Fibonacci m-sequence LFSR.
// Seeds the LFSR, streams frame_len bits per frame over valid/ready, inserts
// GAP_CYC idle cycles between frames, supports continuous mode and abort.
// Optional build macro PRBS_FRAME_CTRL_CHECK_EN adds a self-synchronising
// receive checker (rx_bit/rx_valid in, err_cnt/sync out).
//
// state | meaning
// IDLE  | waiting for start with a non-zero frame length
// LOAD  | one cycle, seed copied into the LFSR (zero seed forced to 8'hFF)
// RUN   | bit_valid high, LFSR advances on each handshake
// GAP   | inter-frame idle, GAP_CYC cycles, LFSR holds
module prbs_frame_ctrl #(
    parameter logic [7:0] POLY    = 8'b10001110,
    parameter int         LEN_W   = 16,
    parameter int         GAP_CYC = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             cont,
    input  logic             abort,
    input  logic [7:0]       seed,
    input  logic [LEN_W-1:0] frame_len,
    output logic             busy,
    output logic             done,
`ifdef PRBS_FRAME_CTRL_CHECK_EN
    input  logic             rx_bit,
    input  logic             rx_valid,
    output logic [15:0]      err_cnt,
    output logic             sync,
`endif
    prbs_frame_ctrl_if.master tx
);

    localparam int GAP_W = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;
    localparam logic [GAP_W-1:0] GAP_INIT = GAP_W'((GAP_CYC > 0) ? GAP_CYC - 1 : 0);

    typedef enum logic [1:0] {IDLE, LOAD, RUN, GAP} state_t;

    state_t           state, state_nx;
    logic [7:0]       shift_reg;
    logic [7:0]       seed_q;
    logic [LEN_W-1:0] len_q;
    logic [LEN_W-1:0] bit_cnt;
    logic [GAP_W-1:0] gap_cnt;
    logic             cont_q;
    logic             latch, shift_ld, shift_adv, cnt_clr, cnt_inc, gap_ld, gap_dec, done_nx;
    logic             hs, last_bit;

    // POLY[7-i] selects shift_reg[i] into the feedback parity
    function automatic logic lfsr_fb(input logic [7:0] s);
        logic fb;
        fb = 1'b0;
        for (int i = 0; i < 8; i++) begin
            fb = fb ^ (s[i] & POLY[7-i]);
        end
        return fb;
    endfunction

    assign tx.bit_out    = shift_reg[0];
    assign tx.bit_valid  = (state == RUN);
    assign last_bit      = (bit_cnt == len_q - LEN_W'(1));
    assign tx.frame_last = (state == RUN) && last_bit;
    assign busy          = (state != IDLE);
    assign hs            = tx.bit_valid && tx.bit_ready;

    // Next-state and datapath strobes; abort overrides everything outside IDLE
    always_comb begin
        state_nx  = state;
        latch     = 1'b0;
        shift_ld  = 1'b0;
        shift_adv = 1'b0;
        cnt_clr   = 1'b0;
        cnt_inc   = 1'b0;
        gap_ld    = 1'b0;
        gap_dec   = 1'b0;
        done_nx   = 1'b0;
        case (state)
            IDLE: begin
                if (start && !abort && (frame_len != '0)) begin
                    latch    = 1'b1;
                    state_nx = LOAD;
                end
            end
            LOAD: begin
                if (abort) begin
                    state_nx = IDLE;
                end else begin
                    shift_ld = 1'b1;
                    cnt_clr  = 1'b1;
                    state_nx = RUN;
                end
            end
            RUN: begin
                if (abort) begin
                    state_nx = IDLE;
                end else if (hs) begin
                    shift_adv = 1'b1;
                    if (last_bit) begin
                        cnt_clr = 1'b1;
                        if (GAP_CYC > 0) begin
                            gap_ld   = 1'b1;
                            state_nx = GAP;
                        end else if (!cont_q) begin
                            done_nx  = 1'b1;
                            state_nx = IDLE;
                        end
                    end else begin
                        cnt_inc = 1'b1;
                    end
                end
            end
            GAP: begin
                if (abort) begin
                    state_nx = IDLE;
                end else if (gap_cnt == '0) begin
                    if (cont_q) begin
                        state_nx = RUN;
                    end else begin
                        done_nx  = 1'b1;
                        state_nx = IDLE;
                    end
                end else begin
                    gap_dec = 1'b1;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // State, LFSR, bit counter, gap down-counter and request capture
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            shift_reg <= 8'hFF;
            seed_q    <= '0;
            len_q     <= '0;
            cont_q    <= 1'b0;
            bit_cnt   <= '0;
            gap_cnt   <= '0;
            done      <= 1'b0;
        end else begin
            state <= state_nx;
            done  <= done_nx;
            if (latch) begin
                seed_q <= seed;
                len_q  <= frame_len;
                cont_q <= cont;
            end
            if (shift_ld) begin
                shift_reg <= (seed_q == 8'h00) ? 8'hFF : seed_q;
            end else if (shift_adv) begin
                shift_reg <= {lfsr_fb(shift_reg), shift_reg[7:1]};
            end
            if (cnt_clr) begin
                bit_cnt <= '0;
            end else if (cnt_inc) begin
                bit_cnt <= bit_cnt + LEN_W'(1);
            end
            if (gap_ld) begin
                gap_cnt <= GAP_INIT;
            end else if (gap_dec) begin
                gap_cnt <= gap_cnt - GAP_W'(1);
            end
        end
    end

`ifdef PRBS_FRAME_CTRL_CHECK_EN
    logic [7:0]  chk_reg;
    logic [2:0]  match_cnt;
    logic [15:0] err_hist, hist_nx;
    logic        chk_pred, chk_miss;

    // Prediction from the last eight received (or predicted) bits
    always_comb begin
        chk_pred = lfsr_fb(chk_reg);
        chk_miss = (rx_bit != chk_pred);
        hist_nx  = {err_hist[14:0], chk_miss};
    end

    // Hunt by shifting raw rx bits; once locked, shift predictions so errors do not propagate
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            chk_reg   <= '0;
            match_cnt <= '0;
            err_hist  <= '0;
            err_cnt   <= '0;
            sync      <= 1'b0;
        end else if (rx_valid) begin
            if (!sync) begin
                chk_reg <= {rx_bit, chk_reg[7:1]};
                if (!chk_miss) begin
                    if (match_cnt == 3'd7) begin
                        sync      <= 1'b1;
                        match_cnt <= '0;
                        err_hist  <= '0;
                    end else begin
                        match_cnt <= match_cnt + 3'd1;
                    end
                end else begin
                    match_cnt <= '0;
                end
            end else begin
                chk_reg  <= {chk_pred, chk_reg[7:1]};
                err_hist <= hist_nx;
                if (chk_miss && (err_cnt != 16'hFFFF)) begin
                    err_cnt <= err_cnt + 16'd1;
                end
                if ($countones(hist_nx) >= 8) begin
                    sync <= 1'b0;
                end
            end
        end
    end
`endif

endmodule

// File: tb/tb_prbs_frame_ctrl.sv
// Directed bench for prbs_frame_ctrl: a table of single frames with
// hand-computed bit patterns, then hand-written sequences for the full
// m-sequence, continuous mode with abort, ignored starts, mid-frame reset
// and (when built with PRBS_FRAME_CTRL_CHECK_EN) the receive checker.
module tb_prbs_frame_ctrl;
    localparam int GAP = 4;

    typedef struct {
        logic [7:0]  seed;
        logic [15:0] len;
        bit          tog;
        logic [15:0] exp_bits;
        string       name;
    } vec_t;

    logic        clk, rst_n, start, cont, abort, busy, done;
    logic [7:0]  seed;
    logic [15:0] frame_len;
    int          total = 0;
    int          bad = 0;
    logic        mb [0:511];
    bit          seen [0:255];
    vec_t        vecs [5];
    logic [15:0] bits, msk;
    logic [17:0] vpat, lpat;
    logic [7:0]  st;
    int          nhs, nlast, ndone, nstab, mism, dup;

    prbs_frame_ctrl_if sif ();

`ifdef PRBS_FRAME_CTRL_CHECK_EN
    logic        rx_flip, rx_bit, rx_valid, sync;
    logic [15:0] err_cnt;
    assign rx_bit   = sif.bit_out ^ rx_flip;
    assign rx_valid = sif.bit_valid & sif.bit_ready;
`endif

    prbs_frame_ctrl #(.POLY(8'b10001110), .LEN_W(16), .GAP_CYC(GAP)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .cont(cont), .abort(abort),
        .seed(seed), .frame_len(frame_len), .busy(busy), .done(done),
`ifdef PRBS_FRAME_CTRL_CHECK_EN
        .rx_bit(rx_bit), .rx_valid(rx_valid), .err_cnt(err_cnt), .sync(sync),
`endif
        .tx(sif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: time limit reached before summary");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Reference stream from the recurrence b[m] = b[m-8]^b[m-4]^b[m-3]^b[m-2]
    task automatic build_model(input logic [7:0] s);
        logic [7:0] e;
        e = (s == 8'h00) ? 8'hFF : s;
        for (int i = 0; i < 8; i++) mb[i] = e[i];
        for (int m = 8; m < 512; m++) mb[m] = mb[m-8] ^ mb[m-4] ^ mb[m-3] ^ mb[m-2];
    endtask

    // Called at a negedge; returns at the next negedge (controller in LOAD)
    task automatic do_start(input logic [7:0] sd, input logic [15:0] ln, input logic c);
        seed = sd; frame_len = ln; cont = c; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic run_frame(input logic [7:0] sd, input logic [15:0] ln, input bit tog,
                             output logic [15:0] b, output int n_hs, output int n_last,
                             output int n_done, output int n_stab);
        int   post;
        logic held_v, held_b;
        b = '0; n_hs = 0; n_last = 0; n_done = 0; n_stab = 0; post = 0; held_v = 0; held_b = 0;
        do_start(sd, ln, 1'b0);
        check("lat_load", {30'd0, busy, sif.bit_valid}, 32'b10);
        @(negedge clk);
        check("lat_run_valid", {31'd0, sif.bit_valid}, 32'd1);
        for (int cyc = 0; cyc < 2000 && post < GAP + 4; cyc++) begin
            sif.bit_ready = tog ? (cyc % 2 == 0) : 1'b1;
            if (done) n_done++;
            if (held_v && (!sif.bit_valid || sif.bit_out !== held_b)) n_stab++;
            held_v = 1'b0;
            if (sif.bit_valid) begin
                if (sif.bit_ready) begin
                    if (n_hs < 16) b[n_hs] = sif.bit_out;
                    if (sif.frame_last !== (n_hs == ln - 1)) n_last++;
                    n_hs++;
                end else begin
                    held_v = 1'b1;
                    held_b = sif.bit_out;
                end
            end
            if (n_hs >= ln) post++;
            @(negedge clk);
        end
        sif.bit_ready = 1'b1;
    endtask

    initial begin
        vecs[0] = '{8'hFF, 16'd16, 1'b0, 16'h84FF, "ff16"};
        vecs[1] = '{8'h01, 16'd16, 1'b0, 16'h8D01, "s01_16"};
        vecs[2] = '{8'hA5, 16'd8,  1'b1, 16'h00A5, "tog8"};
        vecs[3] = '{8'h00, 16'd16, 1'b0, 16'h84FF, "seed0"};
        vecs[4] = '{8'h3C, 16'd12, 1'b1, 16'h063C, "tog12"};

        rst_n = 1'b0; start = 1'b0; cont = 1'b0; abort = 1'b0; seed = '0; frame_len = '0;
        sif.bit_ready = 1'b1;
`ifdef PRBS_FRAME_CTRL_CHECK_EN
        rx_flip = 1'b0;
`endif
        repeat (3) @(negedge clk);
        check("reset_outputs", {27'd0, busy, sif.bit_valid, sif.frame_last, done, sif.bit_out}, 32'b00001);
        rst_n = 1'b1;
        @(negedge clk);

        for (int v = 0; v < 5; v++) begin
            run_frame(vecs[v].seed, vecs[v].len, vecs[v].tog, bits, nhs, nlast, ndone, nstab);
            msk = (vecs[v].len >= 16) ? 16'hFFFF : 16'((32'd1 << vecs[v].len) - 1);
            check({vecs[v].name, "_bits"}, {16'd0, bits & msk}, {16'd0, vecs[v].exp_bits & msk});
            check({vecs[v].name, "_hs"}, nhs, {16'd0, vecs[v].len});
            check({vecs[v].name, "_last"}, nlast, 0);
            check({vecs[v].name, "_done"}, ndone, 1);
            check({vecs[v].name, "_stable"}, nstab, 0);
            check({vecs[v].name, "_idle"}, {31'd0, busy}, 0);
        end

        // full m-sequence from seed 01
        build_model(8'h01);
        for (int i = 0; i < 256; i++) seen[i] = 1'b0;
        do_start(8'h01, 16'd255, 1'b0);
        @(negedge clk);
        nhs = 0; mism = 0; dup = 0; nlast = 0;
        for (int c = 0; c < 400 && nhs < 255; c++) begin
            if (sif.bit_valid) begin
                st = dut.shift_reg;
                if (seen[st]) dup++;
                seen[st] = 1'b1;
                if (sif.bit_out !== mb[nhs]) mism++;
                if (sif.frame_last !== (nhs == 254)) nlast++;
                nhs++;
            end
            @(negedge clk);
        end
        check("m255_hs", nhs, 255);
        check("m255_dup_states", dup, 0);
        check("m255_zero_state", {31'd0, seen[0]}, 0);
        check("m255_bits", mism, 0);
        check("m255_last", nlast, 0);
        check("m255_end_state", {24'd0, dut.shift_reg}, 32'h01);
        ndone = 0;
        for (int c = 0; c < 10; c++) begin
            if (done) ndone++;
            @(negedge clk);
        end
        check("m255_done", ndone, 1);

        // continuous mode, no reseed, abort inside the third frame
        build_model(8'hC3);
        do_start(8'hC3, 16'd4, 1'b1);
        @(negedge clk);
        vpat = '0; lpat = '0; nhs = 0; mism = 0;
        for (int off = 0; off < 18; off++) begin
            vpat[off] = sif.bit_valid;
            lpat[off] = sif.frame_last;
            if (off == 17) begin
                abort = 1'b1;
            end else if (sif.bit_valid) begin
                if (sif.bit_out !== mb[nhs]) mism++;
                nhs++;
            end
            @(negedge clk);
        end
        abort = 1'b0; cont = 1'b0;
        check("cont_valid_pattern", {14'd0, vpat}, 32'h30F0F);
        check("cont_last_pattern", {14'd0, lpat}, 32'h00808);
        check("cont_bits_no_reseed", mism, 0);
        check("cont_hs", nhs, 9);
        check("abort_idle", {30'd0, busy, sif.bit_valid}, 0);
        check("abort_lfsr_hold", {31'd0, sif.bit_out}, {31'd0, mb[9]});
        ndone = 0;
        for (int c = 0; c < 8; c++) begin
            if (done) ndone++;
            @(negedge clk);
        end
        check("abort_no_done", ndone, 0);

        // zero-length start is ignored
        do_start(8'h12, 16'd0, 1'b0);
        check("len0_not_busy", {31'd0, busy}, 0);
        @(negedge clk);
        check("len0_quiet", {29'd0, busy, sif.bit_valid, done}, 0);

        // start while busy is ignored
        sif.bit_ready = 1'b0;
        do_start(8'hFF, 16'd3, 1'b0);
        @(negedge clk);
        seed = 8'h01; frame_len = 16'd100; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("busy_start_stalled", {30'd0, busy, sif.bit_valid}, 32'b11);
        sif.bit_ready = 1'b1;
        nhs = 0; bits = '0; ndone = 0;
        for (int c = 0; c < 20; c++) begin
            if (done) ndone++;
            if (sif.bit_valid) begin
                if (nhs < 16) bits[nhs] = sif.bit_out;
                nhs++;
            end
            @(negedge clk);
        end
        check("busy_start_hs", nhs, 3);
        check("busy_start_bits", {16'd0, bits}, 32'h7);
        check("busy_start_done", ndone, 1);

        // reset in the middle of a frame
        do_start(8'h01, 16'd50, 1'b0);
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check("midreset_outputs", {27'd0, busy, sif.bit_valid, sif.frame_last, done, sif.bit_out}, 32'b00001);
        rst_n = 1'b1;
        @(negedge clk);

`ifdef PRBS_FRAME_CTRL_CHECK_EN
        rst_n = 1'b0;
        @(negedge clk);
        check("chk_reset", {15'd0, sync, err_cnt}, 0);
        rst_n = 1'b1;
        @(negedge clk);
        do_start(8'h3C, 16'd60, 1'b0);
        @(negedge clk);
        nhs = 0;
        for (int c = 0; c < 100 && nhs < 60; c++) begin
            rx_flip = sif.bit_valid && (nhs == 20 || nhs == 30 || nhs == 40);
            if (sif.bit_valid && nhs == 16) check("chk_sync16", {31'd0, sync}, 1);
            if (sif.bit_valid) nhs++;
            @(negedge clk);
        end
        rx_flip = 1'b0;
        check("chk_err3", {16'd0, err_cnt}, 3);
        check("chk_still_sync", {31'd0, sync}, 1);
        repeat (GAP + 3) @(negedge clk);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
